// File: rtl/sum_addsub_seq_if.sv
// Chunk-serial add/subtract bus: operand chunks in, result chunks and
// status out. The master drives the operands; the slave is the datapath.
interface sum_addsub_seq_if #(
  parameter int W = 16
);
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         c_valid;
  logic         busy;
  logic         done;
  logic         carry_out;

  modport master (
    output start, sub, a, b,
    input  c, c_valid, busy, done, carry_out
  );

  modport slave (
    input  start, sub, a, b,
    output c, c_valid, busy, done, carry_out
  );
endinterface

// File: rtl/sum_addsub_seq.sv
// Chunk-serial W*CC-bit adder/subtractor. Operands arrive W bits per cycle,
// least-significant chunk first; each result chunk is registered one cycle
// later. Subtraction is a + ~b + 1, with the +1 injected as the chunk-0
// carry-in and the carry chained between chunks through carry_q.
module sum_addsub_seq #(
  parameter int W  = 16,
  parameter int CC = 8
) (
  input  logic             clk,
  input  logic             rst,
  sum_addsub_seq_if.slave  io
);

  localparam int KW = (CC > 1) ? $clog2(CC) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            mode_q;
  logic            carry_q;
  logic [W-1:0]    c_q;
  logic            c_valid_q;
  logic            done_q;
  logic            carry_out_q;

  logic            accept;
  logic            proc;
  logic            last;
  logic            sub_eff;
  logic            cin;
  logic [W-1:0]    b_eff;
  logic [W:0]      sum;

  // Chunk datapath: pick mode and carry-in (fresh on the accepting cycle,
  // registered otherwise) and form the W+1-bit chunk sum.
  // NOTE: every signal assigned in an always_comb gets a value on every
  // path, otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    accept  = (state_q == IDLE) && io.start;
    proc    = accept || (state_q == RUN);
    sub_eff = accept ? io.sub : mode_q;
    cin     = accept ? io.sub : carry_q;
    b_eff   = sub_eff ? ~io.b : io.b;
    sum     = {1'b0, io.a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
    if (CC == 1) begin
      last = accept;
    end else begin
      last = (state_q == RUN) && (k_q == KW'(CC - 1));
    end
  end

  // Next-state and chunk-counter logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (accept && (CC > 1)) begin
          state_d = RUN;
          k_d     = KW'(1);
        end
      end
      RUN: begin
        if (last) begin
          state_d = IDLE;
          k_d     = '0;
        end else begin
          k_d     = k_q + KW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // State, counter, mode/carry chain and registered outputs.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      mode_q      <= 1'b0;
      carry_q     <= 1'b0;
      c_q         <= '0;
      c_valid_q   <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      c_valid_q <= proc;
      done_q    <= proc && last;
      if (accept) begin
        mode_q <= io.sub;
      end
      if (proc) begin
        c_q     <= sum[W-1:0];
        carry_q <= sum[W];
      end
      if (proc && last) begin
        carry_out_q <= sum[W];
      end
    end
  end

  assign io.c         = c_q;
  assign io.c_valid   = c_valid_q;
  assign io.done      = done_q;
  assign io.carry_out = carry_out_q;
  assign io.busy      = (state_q == RUN);

endmodule

// File: tb/tb_sum_addsub_seq.sv
// Scoreboard bench for sum_addsub_seq: a W=16/CC=8 instance and a W=8/CC=1
// instance. Stimulus pushes hand-computed expected chunks (with the cycle
// they must appear in); monitors pop and compare on every c_valid.
module tb_sum_addsub_seq;

  typedef logic [15:0] vec_t [8];
  typedef struct {
    logic [15:0] c;
    logic        done;
    logic        cout;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  logic busy1_seen = 1'b0;

  exp_t q[$];
  exp_t q1[$];

  sum_addsub_seq_if #(.W(16)) bus();
  sum_addsub_seq_if #(.W(8))  bus1();

  sum_addsub_seq #(.W(16), .CC(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  sum_addsub_seq #(.W(8), .CC(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .io  (bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the CC=8 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.c_valid) begin
      if (q.size() == 0) begin
        check("unexpected_c_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("c", {16'd0, bus.c}, {16'd0, e.c});
        check("done", {31'd0, bus.done}, {31'd0, e.done});
        check("latency_cycle", cyc, e.cyc);
        if (e.done) check("carry_out", {31'd0, bus.carry_out}, {31'd0, e.cout});
      end
    end else if (bus.done) begin
      check("done_without_valid", 32'd1, 32'd0);
    end
  end

  // Monitor for the CC=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (bus1.busy) busy1_seen = 1'b1;
    if (!rst && bus1.c_valid) begin
      if (q1.size() == 0) begin
        check("cc1_unexpected_c_valid", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check("cc1_c", {24'd0, bus1.c}, {16'd0, e.c});
        check("cc1_done", {31'd0, bus1.done}, {31'd0, e.done});
        check("cc1_latency_cycle", cyc, e.cyc);
        check("cc1_carry_out", {31'd0, bus1.carry_out}, {31'd0, e.cout});
      end
    end
  end

  // One full operation; releases reset on chunk 0 so the first start lands
  // on the first edge after deassertion. sub is toggled after chunk 0 to
  // show it is only sampled on the accepting cycle.
  task automatic run_op(input logic s, input vec_t av, input vec_t bv,
                        input vec_t ev, input logic ecout);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      rst       = 1'b0;
      bus.start = (i == 0);
      bus.sub   = (i == 0) ? s : ~s;
      bus.a     = av[i];
      bus.b     = bv[i];
      e.c    = ev[i];
      e.done = (i == 7);
      e.cout = ecout;
      e.cyc  = cyc + 1;
      q.push_back(e);
      if (i == 1) check("busy_in_run", {31'd0, bus.busy}, 32'd1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus1.start = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_c"}, {16'd0, bus.c}, 32'd0);
    check({tag, "_c_valid"}, {31'd0, bus.c_valid}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_carry_out"}, {31'd0, bus.carry_out}, 32'd0);
  endtask

  initial begin
    vec_t all_ffff, one_lsb, zeros, all_1234, all_2468, all_ffff_v, carry1_a, carry1_c;
    exp_t e;
    all_ffff   = '{default: 16'hFFFF};
    all_ffff_v = '{default: 16'hFFFF};
    zeros      = '{default: 16'h0000};
    all_1234   = '{default: 16'h1234};
    all_2468   = '{default: 16'h2468};
    one_lsb    = '{16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    carry1_a   = '{16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    carry1_c   = '{16'h0000, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    check("cc1_reset_c_valid", {31'd0, bus1.c_valid}, 32'd0);
    check("cc1_reset_carry_out", {31'd0, bus1.carry_out}, 32'd0);

    // Add all-ones + 1: every chunk wraps to zero, final carry 1.
    run_op(1'b0, all_ffff, one_lsb, zeros, 1'b1);
    idle(2);
    check("hold_c_valid_low", {31'd0, bus.c_valid}, 32'd0);
    check("hold_c", {16'd0, bus.c}, 32'h0000);
    check("hold_carry_out", {31'd0, bus.carry_out}, 32'd1);

    // Sub 0 - 1: borrow ripples through every chunk.
    run_op(1'b1, zeros, one_lsb, all_ffff_v, 1'b0);
    idle(2);
    check("hold_c_ffff", {16'd0, bus.c}, 32'h0000FFFF);
    check("hold_borrow", {31'd0, bus.carry_out}, 32'd0);

    // Carry out of chunk 0 must land in chunk 1 only.
    run_op(1'b0, carry1_a, one_lsb, carry1_c, 1'b0);
    idle(1);

    // Back-to-back: add (carry_out 0) then sub with zero gap; the sub's
    // chunk-0 carry-in must be 1 regardless of the add's final carry.
    run_op(1'b0, all_1234, all_1234, all_2468, 1'b0);
    run_op(1'b1, all_1234, all_1234, zeros, 1'b1);
    idle(2);

    // Start (with sub=1) in RUN at chunk 3 is ignored; reset at chunk 5
    // abandons the operation.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      bus.start = (i == 0) || (i == 3);
      bus.sub   = (i == 3);
      bus.a     = 16'h1234;
      bus.b     = 16'h1234;
      e.c = 16'h2468; e.done = 1'b0; e.cout = 1'b0; e.cyc = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk); #1;
    rst = 1'b1;
    bus.start = 1'b0;
    #1;
    check_all_zero("midop_reset");
    @(negedge clk); #1;
    check("midop_reset_held_c_valid", {31'd0, bus.c_valid}, 32'd0);
    run_op(1'b0, all_ffff, one_lsb, zeros, 1'b1);
    idle(2);

    // CC=1, W=8: 0xFF+0x01 then back-to-back 0x05-0x07.
    @(negedge clk); #1;
    bus1.start = 1'b1; bus1.sub = 1'b0; bus1.a = 8'hFF; bus1.b = 8'h01;
    e.c = 16'h0000; e.done = 1'b1; e.cout = 1'b1; e.cyc = cyc + 1;
    q1.push_back(e);
    @(negedge clk); #1;
    bus1.start = 1'b1; bus1.sub = 1'b1; bus1.a = 8'h05; bus1.b = 8'h07;
    e.c = 16'h00FE; e.done = 1'b1; e.cout = 1'b0; e.cyc = cyc + 1;
    q1.push_back(e);
    idle(3);
    check("cc1_busy_never", {31'd0, busy1_seen}, 32'd0);

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && (q.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    check("scoreboard_drained", q.size() + q1.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
